// File: rtl/mpeg_stream_fifo_pkg.sv
// Shared MPEG input-path definitions.
// Holds the default FIFO geometry and the output word width helper so the
// stream FIFO and the bitstream parser agree on the word type.
package mpeg_stream_fifo_pkg;

    // Default capacity: 2^13 = 8192 bytes.
    localparam int MPEG_BYTE_ADDR_W = 13;
    // Default bytes-per-word exponent: 2^2 = 4 bytes -> 32-bit word.
    localparam int MPEG_RATIO_LOG2  = 2;

    // Output word width in bits for a given bytes-per-word exponent.
    function automatic int mpeg_word_width(input int ratio_log2);
        return 8 << ratio_log2;
    endfunction

    localparam int MPEG_WORD_W = 8 << MPEG_RATIO_LOG2;

    // Little-endian parser word: byte k lives at bits [8k+7:8k].
    typedef logic [MPEG_WORD_W-1:0] mpeg_word_t;

endpackage

// File: rtl/mpeg_stream_fifo_ram.sv
// Mixed-width simple dual-port RAM for the MPEG stream FIFO.
// Byte-wide write port, word-wide read port with a one-cycle registered read.
// Storage is split into one byte lane per word byte so every lane is a plain
// single-width array with one write and one read port.
//
// Ports:
//   clk      in   clock
//   wr_en    in   write strobe
//   wr_addr  in   byte address (BYTE_ADDR_W bits)
//   wr_data  in   byte to store
//   rd_en    in   read strobe; rd_data updates on the next rising edge
//   rd_addr  in   word address (BYTE_ADDR_W-RATIO_LOG2 bits)
//   rd_data  out  word read, lane k at bits [8k+7:8k]
module mpeg_stream_fifo_ram
    import mpeg_stream_fifo_pkg::*;
#(
    parameter int BYTE_ADDR_W = MPEG_BYTE_ADDR_W,
    parameter int RATIO_LOG2  = MPEG_RATIO_LOG2
) (
    input  logic                                      clk,
    input  logic                                      wr_en,
    input  logic [BYTE_ADDR_W-1:0]                    wr_addr,
    input  logic [7:0]                                wr_data,
    input  logic                                      rd_en,
    input  logic [BYTE_ADDR_W-RATIO_LOG2-1:0]         rd_addr,
    output logic [mpeg_word_width(RATIO_LOG2)-1:0]    rd_data
);

    localparam int LANES  = 1 << RATIO_LOG2;
    localparam int WORDS  = 1 << (BYTE_ADDR_W - RATIO_LOG2);
    localparam int WADDR_W = BYTE_ADDR_W - RATIO_LOG2;

    // Low address bits pick the lane, high bits pick the word row.
    logic [RATIO_LOG2-1:0] wr_lane;
    logic [WADDR_W-1:0]    wr_row;

    assign wr_lane = wr_addr[RATIO_LOG2-1:0];
    assign wr_row  = wr_addr[BYTE_ADDR_W-1:RATIO_LOG2];

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] mem [WORDS];
            logic [7:0] q_reg;

            always_ff @(posedge clk) begin
                if (wr_en && (wr_lane == RATIO_LOG2'(gi))) begin
                    mem[wr_row] <= wr_data;
                end
                if (rd_en) begin
                    q_reg <= mem[rd_addr];
                end
            end

            assign rd_data[8*gi +: 8] = q_reg;
        end
    endgenerate

endmodule

// File: rtl/mpeg_stream_fifo.sv
// Byte-in / word-out stream FIFO for the MPEG input path.
// Bytes from the CD sector/DMA side are written one per cycle and leave as
// little-endian words towards the bitstream parser. A two-entry output buffer
// behind the registered RAM read keeps one word per cycle flowing while the
// consumer is ready, and decouples every output from the handshake inputs.
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   synchronous active-high reset
//   flush        in   synchronous clear of all contents (same as reset)
//   wr_valid     in   byte offered
//   wr_data      in   byte
//   wr_ready     out  !full
//   rd_valid     out  word available at buffer head
//   rd_data      out  buffer head word
//   rd_ready     in   consumer accepts word
//   level_bytes  out  bytes held (RAM + in-flight/buffered words)
//   full         out  RAM holds 2^BYTE_ADDR_W bytes
//   empty        out  level_bytes == 0
module mpeg_stream_fifo
    import mpeg_stream_fifo_pkg::*;
#(
    parameter int BYTE_ADDR_W = MPEG_BYTE_ADDR_W,
    parameter int RATIO_LOG2  = MPEG_RATIO_LOG2   // legal range 1..3
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    flush,
    input  logic                                    wr_valid,
    input  logic [7:0]                              wr_data,
    output logic                                    wr_ready,
    output logic                                    rd_valid,
    output logic [mpeg_word_width(RATIO_LOG2)-1:0]  rd_data,
    input  logic                                    rd_ready,
    output logic [BYTE_ADDR_W:0]                    level_bytes,
    output logic                                    full,
    output logic                                    empty
);

    localparam int WORD_W  = mpeg_word_width(RATIO_LOG2);
    localparam int RPTR_W  = BYTE_ADDR_W + 1 - RATIO_LOG2;
    localparam int WADDR_W = BYTE_ADDR_W - RATIO_LOG2;

    logic [BYTE_ADDR_W:0] wptr_reg;
    logic [RPTR_W-1:0]    rptr_reg;
    logic [1:0]           occ_reg, occ_next;
    logic                 inflight_reg;
    logic [WORD_W-1:0]    obuf_reg [2];
    logic [WORD_W-1:0]    obuf0_next, obuf1_next;

    logic [BYTE_ADDR_W:0] ram_bytes;
    logic [RPTR_W-1:0]    words_avail;
    logic [2:0]           slots;
    logic [BYTE_ADDR_W:0] slot_bytes;
    logic                 wr_fire;
    logic                 pop;
    logic                 push;
    logic                 issue;
    logic [WORD_W-1:0]    ram_q;

    // Pointer difference; the wrap bit makes a completely full RAM
    // (2^BYTE_ADDR_W bytes) distinguishable from an empty one.
    assign ram_bytes   = wptr_reg - {rptr_reg, {RATIO_LOG2{1'b0}}};
    // Trailing bytes of an incomplete word are shifted out here, so a word is
    // only ever issued once all its bytes are in the RAM.
    assign words_avail = ram_bytes[BYTE_ADDR_W:RATIO_LOG2];

    assign full     = ram_bytes[BYTE_ADDR_W];
    assign wr_ready = !full;
    assign rd_valid = (occ_reg != 2'd0);
    assign rd_data  = obuf_reg[0];

    assign wr_fire = wr_valid && !full;
    assign pop     = rd_valid && rd_ready;
    assign push    = inflight_reg;

    // Buffer slots claimed by words already out of the RAM. Issue while the
    // claim after this cycle's pop still leaves room for the returning word.
    assign slots = {1'b0, occ_reg} + {2'b00, inflight_reg};
    assign issue = (words_avail != '0) && (slots < (3'd2 + {2'b00, pop}));

    // An in-flight word is counted with the buffer so a read issue moves
    // bytes between RAM and buffer without disturbing the level.
    assign slot_bytes  = {{(BYTE_ADDR_W + 1 - 3 - RATIO_LOG2){1'b0}}, slots, {RATIO_LOG2{1'b0}}};
    assign level_bytes = ram_bytes + slot_bytes;
    assign empty       = (level_bytes == '0);

    mpeg_stream_fifo_ram #(
        .BYTE_ADDR_W (BYTE_ADDR_W),
        .RATIO_LOG2  (RATIO_LOG2)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_fire && !flush),
        .wr_addr (wptr_reg[BYTE_ADDR_W-1:0]),
        .wr_data (wr_data),
        .rd_en   (issue),
        .rd_addr (rptr_reg[WADDR_W-1:0]),
        .rd_data (ram_q)
    );

    // Output buffer: entry 0 is the head. A returning word lands in the first
    // free entry after this cycle's pop has shifted the buffer.
    always_comb begin
        occ_next   = occ_reg;
        obuf0_next = obuf_reg[0];
        obuf1_next = obuf_reg[1];
        case ({push, pop})
            2'b10: begin
                if (occ_reg == 2'd0) begin
                    obuf0_next = ram_q;
                end else begin
                    obuf1_next = ram_q;
                end
                occ_next = occ_reg + 2'd1;
            end
            2'b01: begin
                obuf0_next = obuf_reg[1];
                occ_next   = occ_reg - 2'd1;
            end
            2'b11: begin
                if (occ_reg == 2'd1) begin
                    obuf0_next = ram_q;
                end else begin
                    obuf0_next = obuf_reg[1];
                    obuf1_next = ram_q;
                end
            end
            default: ;
        endcase
    end

    // Flush shares the reset path so it overrides any write, issue or pop
    // and drops a word returning from the RAM in that cycle.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wptr_reg     <= '0;
            rptr_reg     <= '0;
            occ_reg      <= 2'd0;
            inflight_reg <= 1'b0;
            obuf_reg[0]  <= '0;
            obuf_reg[1]  <= '0;
        end else begin
            if (wr_fire) begin
                wptr_reg <= wptr_reg + 1'b1;
            end
            if (issue) begin
                rptr_reg <= rptr_reg + 1'b1;
            end
            inflight_reg <= issue;
            occ_reg      <= occ_next;
            obuf_reg[0]  <= obuf0_next;
            obuf_reg[1]  <= obuf1_next;
        end
    end

endmodule

// File: tb/tb_mpeg_stream_fifo.sv
module tb_mpeg_stream_fifo;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        wr_valid;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_ready;
    logic [13:0] level_bytes;
    logic        full;
    logic        empty;

    int vectors     = 0;
    int miscompares = 0;

    mpeg_stream_fifo #(
        .BYTE_ADDR_W (13),
        .RATIO_LOG2  (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_ready    (rd_ready),
        .level_bytes (level_bytes),
        .full        (full),
        .empty       (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_valid = 1'b1;
        wr_data  = b;
        step();
        wr_valid = 1'b0;
    endtask

    function automatic logic [31:0] word_of(input int base);
        logic [7:0] b0, b1, b2, b3;
        b0 = 8'(base);
        b1 = 8'(base + 1);
        b2 = 8'(base + 2);
        b3 = 8'(base + 3);
        return {b3, b2, b1, b0};
    endfunction

    initial begin
        int accepted;
        int exp_idx;
        int sent;
        int ridx;

        reset    = 1'b1;
        flush    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        rd_ready = 1'b0;
        step();
        step();
        reset = 1'b0;

        // Reset values
        check("rst_wr_ready", wr_ready, 1);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_level", level_bytes, 0);
        check("rst_full", full, 0);
        check("rst_empty", empty, 1);

        // Single word, latency 2 edges after the last byte
        rd_ready = 1'b1;
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        write_byte(8'h44);
        check("sw_level4", level_bytes, 4);
        check("sw_valid_e4", rd_valid, 0);
        step();
        check("sw_valid_e5", rd_valid, 0);
        check("sw_level_inflight", level_bytes, 4);
        step();
        check("sw_valid_e6", rd_valid, 1);
        check("sw_data", rd_data, 32'h44332211);
        step();
        check("sw_level0", level_bytes, 0);
        check("sw_empty", empty, 1);
        check("sw_valid_after", rd_valid, 0);

        // Partial word stays invisible
        write_byte(8'hA1);
        write_byte(8'hA2);
        write_byte(8'hA3);
        step();
        step();
        step();
        check("pw_valid", rd_valid, 0);
        check("pw_level3", level_bytes, 3);
        check("pw_empty", empty, 0);
        write_byte(8'hA4);
        step();
        step();
        check("pw_valid_word", rd_valid, 1);
        check("pw_data", rd_data, 32'hA4A3A2A1);
        step();
        check("pw_empty_after", empty, 1);

        // Fill to full: RAM capacity plus the two buffered words
        rd_ready = 1'b0;
        wr_valid = 1'b1;
        accepted = 0;
        for (int c = 0; c < 9000 && wr_ready; c++) begin
            wr_data = accepted[7:0];
            step();
            accepted++;
        end
        check("fill_accepted", accepted, 8200);
        check("fill_full", full, 1);
        check("fill_wr_ready", wr_ready, 0);
        check("fill_level", level_bytes, 8200);
        wr_data = accepted[7:0];
        step();
        check("fill_reject_level", level_bytes, 8200);
        wr_valid = 1'b0;
        check("fill_head", rd_data, 32'h03020100);
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        check("unfull_full", full, 0);
        check("unfull_wr_ready", wr_ready, 1);
        check("unfull_level", level_bytes, 8196);

        // Drain everything in order
        exp_idx  = 4;
        rd_ready = 1'b1;
        for (int c = 0; c < 10000 && exp_idx < 8200; c++) begin
            if (rd_valid) begin
                check("drain_word", rd_data, word_of(exp_idx));
                exp_idx += 4;
            end
            step();
        end
        rd_ready = 1'b0;
        check("drain_count", exp_idx, 8200);
        check("drain_empty", empty, 1);

        // Back-pressure and throughput: 16 words buffered
        for (int i = 0; i < 64; i++) begin
            write_byte(8'(8'h40 + i));
        end
        step();
        step();
        step();
        check("bp_level", level_bytes, 64);
        rd_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            if (j == 8) begin
                rd_ready = 1'b0;
                step();
                step();
                check("bp_hold_valid", rd_valid, 1);
                check("bp_hold_data", rd_data, word_of(8'h40 + 32));
                rd_ready = 1'b1;
            end
            check("bp_valid", rd_valid, 1);
            check("bp_data", rd_data, word_of(8'h40 + 4 * j));
            step();
        end
        rd_ready = 1'b0;
        check("bp_empty", empty, 1);
        check("bp_valid_end", rd_valid, 0);

        // Long stream across pointer wrap with random back-pressure
        sent = 0;
        ridx = 0;
        for (int c = 0; c < 60000 && ridx < 20000; c++) begin
            wr_valid = (sent < 20000);
            wr_data  = sent[7:0];
            rd_ready = 1'($urandom_range(0, 1));
            if (wr_valid && wr_ready) sent++;
            if (rd_valid && rd_ready) begin
                check("stream_word", rd_data, word_of(ridx));
                ridx += 4;
            end
            step();
        end
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        check("stream_count", ridx, 20000);
        check("stream_empty", empty, 1);

        // Flush with a read in flight and a write presented
        rd_ready = 1'b1;
        write_byte(8'hB0);
        write_byte(8'hB1);
        write_byte(8'hB2);
        write_byte(8'hB3);
        write_byte(8'hB4);
        flush    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'hEE;
        step();
        flush    = 1'b0;
        wr_valid = 1'b0;
        check("fl_wr_ready", wr_ready, 1);
        check("fl_rd_valid", rd_valid, 0);
        check("fl_rd_data", rd_data, 0);
        check("fl_level", level_bytes, 0);
        check("fl_full", full, 0);
        check("fl_empty", empty, 1);
        step();
        step();
        check("fl_no_ghost", rd_valid, 0);
        write_byte(8'hC0);
        write_byte(8'hC1);
        write_byte(8'hC2);
        write_byte(8'hC3);
        step();
        step();
        check("fl_new_valid", rd_valid, 1);
        check("fl_new_data", rd_data, 32'hC3C2C1C0);
        step();
        check("fl_new_empty", empty, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
